// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operand loader: state encoding and default widths.
package ula_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_OPW   = 4;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef enum logic [1:0] {
    StLoad  = LOAD,
    StIssue = ISSUE,
    StWait  = WAIT
  } state_e;

endpackage

// File: rtl/operand_reg.sv
// WIDTH-bit operand register with load enable and synchronous clear.
module operand_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ula_operand_loader.sv
// Captures two bus operands and an opcode, issues a one-cycle go to the ULA, then holds
// operands until ula_done. Define ULA_OPERAND_FWD_EN to chain ula_result back into operand A.
module ula_operand_loader
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OPW   = DEF_OPW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_bus,
  input  logic             grab_a,
  input  logic             grab_b,
  input  logic [OPW-1:0]   opcode,
  input  logic             start,
  input  logic             ula_done,
`ifdef ULA_OPERAND_FWD_EN
  input  logic [WIDTH-1:0] ula_result,
  input  logic             fwd_a,
`endif
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [OPW-1:0]   ula_op,
  output logic             ula_go,
  output logic             busy,
  output logic             err
);

  state_e         state_q;
  logic           a_vld_q, b_vld_q;
  logic [OPW-1:0] op_q;
  logic           go_q, err_q;

  logic             in_load, accept, reject;
  logic             ld_a, ld_b, fwd_take;
  logic [WIDTH-1:0] d_a;

  assign in_load = (state_q == StLoad);
  assign accept  = in_load && start && (a_vld_q || grab_a) && (b_vld_q || grab_b);
  // A rejected start leaves the operands untouched, even with a grab in the same cycle.
  assign reject  = in_load && start && !accept;

`ifdef ULA_OPERAND_FWD_EN
  assign fwd_take = (state_q == StWait) && ula_done && fwd_a;
  assign d_a      = fwd_take ? ula_result : data_bus;
`else
  assign fwd_take = 1'b0;
  assign d_a      = data_bus;
`endif

  assign ld_a = (in_load && grab_a && !reject) || fwd_take;
  assign ld_b = in_load && grab_b && !reject;

  operand_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clock (clock),
    .clear (reset),
    .load  (ld_a),
    .d     (d_a),
    .q     (operand_a)
  );

  operand_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clock (clock),
    .clear (reset),
    .load  (ld_b),
    .d     (data_bus),
    .q     (operand_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLoad;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      op_q    <= '0;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      go_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (ld_a) a_vld_q <= 1'b1;
          if (ld_b) b_vld_q <= 1'b1;
          if (accept) begin
            op_q    <= opcode;
            go_q    <= 1'b1;
            state_q <= StIssue;
          end else if (reject) begin
            err_q <= 1'b1;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (ula_done) begin
            state_q <= StLoad;
            a_vld_q <= fwd_take;
            b_vld_q <= 1'b0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign ula_op = op_q;
  assign ula_go = go_q;
  assign err    = err_q;
  assign busy   = (state_q != StLoad);

endmodule

// File: tb/tb_ula_operand_loader.sv
// Scoreboard bench for ula_operand_loader; define ULA_OPERAND_FWD_EN to cover result chaining.
module tb_ula_operand_loader;

  logic       clock = 1'b0;
  logic       reset, grab_a, grab_b, start, ula_done, fwd_a;
  logic [7:0] data_bus, ula_result;
  logic [3:0] opcode;
  logic [7:0] operand_a, operand_b;
  logic [3:0] ula_op;
  logic       ula_go, busy, err;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clock = ~clock;

  ula_operand_loader dut (
    .clock      (clock),
    .reset      (reset),
    .data_bus   (data_bus),
    .grab_a     (grab_a),
    .grab_b     (grab_b),
    .opcode     (opcode),
    .start      (start),
    .ula_done   (ula_done),
`ifdef ULA_OPERAND_FWD_EN
    .ula_result (ula_result),
    .fwd_a      (fwd_a),
`endif
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .ula_op     (ula_op),
    .ula_go     (ula_go),
    .busy       (busy),
    .err        (err)
  );

  // Every go pulse must match the oldest expected issue.
  always @(negedge clock) begin
    if (ula_go === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL issue_unexpected: ula_go=1 with no issue expected");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({operand_a, operand_b, ula_op} !== {e.a, e.b, e.op}) begin
          n_miss++;
          $display("FAIL issue_payload: got a=%h b=%h op=%h, want a=%h b=%h op=%h",
                   operand_a, operand_b, ula_op, e.a, e.b, e.op);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    grab_a = 0; grab_b = 0; start = 0; ula_done = 0; fwd_a = 0;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1; idle(); data_bus = 8'h00; opcode = 4'h0; ula_result = 8'h00;
    tick(); tick();
    reset = 0;
    chk("rst_operand_a", operand_a, 8'h00);
    chk("rst_operand_b", operand_b, 8'h00);
    chk("rst_ula_op", {4'h0, ula_op}, 8'h00);
    chk("rst_ula_go", {7'h0, ula_go}, 8'h00);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    chk("rst_err", {7'h0, err}, 8'h00);
  endtask

  task automatic test_basic();
    data_bus = 8'h12; grab_a = 1; tick(); grab_a = 0;
    chk("basic_a_visible", operand_a, 8'h12);
    data_bus = 8'h34; grab_b = 1; tick(); grab_b = 0;
    chk("basic_b_visible", operand_b, 8'h34);
    opcode = 4'h3; start = 1;
    exp_q.push_back('{a: 8'h12, b: 8'h34, op: 4'h3});
    tick(); start = 0;
    chk("basic_go_issue", {7'h0, ula_go}, 8'h01);
    chk("basic_busy_issue", {7'h0, busy}, 8'h01);
    chk("basic_ula_op", {4'h0, ula_op}, 8'h03);
    tick();
    chk("basic_go_wait", {7'h0, ula_go}, 8'h00);
    chk("basic_busy_wait", {7'h0, busy}, 8'h01);
    ula_done = 1; tick(); ula_done = 0;
    chk("basic_busy_done", {7'h0, busy}, 8'h00);
    chk("basic_a_held", operand_a, 8'h12);
  endtask

  task automatic test_reject();
    data_bus = 8'h55; grab_a = 1; tick(); grab_a = 0;
    start = 1; tick(); start = 0;
    chk("rej_err", {7'h0, err}, 8'h01);
    chk("rej_go", {7'h0, ula_go}, 8'h00);
    chk("rej_busy", {7'h0, busy}, 8'h00);
    tick();
    chk("rej_err_clear", {7'h0, err}, 8'h00);
    chk("rej_a", operand_a, 8'h55);
  endtask

  task automatic test_same_cycle();
    data_bus = 8'hA5; grab_a = 1; grab_b = 1; start = 1; opcode = 4'h9;
    exp_q.push_back('{a: 8'hA5, b: 8'hA5, op: 4'h9});
    tick(); idle();
    chk("same_a", operand_a, 8'hA5);
    chk("same_b", operand_b, 8'hA5);
    chk("same_go", {7'h0, ula_go}, 8'h01);
    tick();
  endtask

  task automatic test_wait_ignore();
    data_bus = 8'hFF; grab_a = 1; grab_b = 1; start = 1; opcode = 4'hC;
    tick(); idle();
    chk("wait_a_held", operand_a, 8'hA5);
    chk("wait_b_held", operand_b, 8'hA5);
    chk("wait_op_held", {4'h0, ula_op}, 8'h09);
    chk("wait_no_err", {7'h0, err}, 8'h00);
    chk("wait_busy", {7'h0, busy}, 8'h01);
    ula_done = 1; tick(); ula_done = 0;
    chk("wait_done_load", {7'h0, busy}, 8'h00);
    start = 1; tick(); start = 0;
    chk("wait_flags_cleared_err", {7'h0, err}, 8'h01);
    chk("wait_flags_cleared_go", {7'h0, ula_go}, 8'h00);
  endtask

  task automatic test_reset_in_wait();
    data_bus = 8'h3C; grab_a = 1; grab_b = 1; start = 1; opcode = 4'h5;
    exp_q.push_back('{a: 8'h3C, b: 8'h3C, op: 4'h5});
    tick(); idle(); tick();
    chk("rw_busy_before", {7'h0, busy}, 8'h01);
    reset = 1; tick(); reset = 0;
    chk("rw_a", operand_a, 8'h00);
    chk("rw_b", operand_b, 8'h00);
    chk("rw_op", {4'h0, ula_op}, 8'h00);
    chk("rw_busy", {7'h0, busy}, 8'h00);
    ula_done = 1; tick(); ula_done = 0;
    chk("rw_done_ignored_busy", {7'h0, busy}, 8'h00);
    chk("rw_done_ignored_go", {7'h0, ula_go}, 8'h00);
    start = 1; tick(); start = 0;
    chk("rw_flags_cleared", {7'h0, err}, 8'h01);
  endtask

  task automatic test_back_to_back();
    // Done sampled at M, new start accepted at M+1: 3-cycle issue period.
    data_bus = 8'h21; grab_a = 1; grab_b = 1; start = 1; opcode = 4'h1;
    exp_q.push_back('{a: 8'h21, b: 8'h21, op: 4'h1});
    tick(); idle(); tick();
    ula_done = 1; tick(); ula_done = 0;
    data_bus = 8'h42; grab_a = 1; grab_b = 1; start = 1; opcode = 4'h2;
    exp_q.push_back('{a: 8'h42, b: 8'h42, op: 4'h2});
    tick(); idle();
    chk("b2b_go", {7'h0, ula_go}, 8'h01);
    tick(); ula_done = 1; tick(); ula_done = 0;
  endtask

`ifdef ULA_OPERAND_FWD_EN
  task automatic test_fwd();
    data_bus = 8'h10; grab_a = 1; grab_b = 1; start = 1; opcode = 4'h2;
    exp_q.push_back('{a: 8'h10, b: 8'h10, op: 4'h2});
    tick(); idle(); tick();
    ula_result = 8'h77; fwd_a = 1; ula_done = 1; tick(); idle();
    chk("fwd_a_loaded", operand_a, 8'h77);
    chk("fwd_busy", {7'h0, busy}, 8'h00);
    data_bus = 8'h01; grab_b = 1; start = 1; opcode = 4'h4;
    exp_q.push_back('{a: 8'h77, b: 8'h01, op: 4'h4});
    tick(); idle();
    chk("fwd_go", {7'h0, ula_go}, 8'h01);
    chk("fwd_no_err", {7'h0, err}, 8'h00);
    tick(); ula_done = 1; tick(); ula_done = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_same_cycle();
    test_wait_ignore();
    test_reset_in_wait();
    test_back_to_back();
`ifdef ULA_OPERAND_FWD_EN
    test_fwd();
`endif
    tick(); tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL issue_missing: %0d expected issues never seen, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
